// File: rtl/vblank_seq_pkg.sv
// Shared timing definitions for the vertical-blanking sequencer: register width, FSM encoding, default XV patterns.
// Latency/backpressure: not applicable (definitions only).
package vblank_seq_pkg;

    localparam int REG_WD = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } vb_state_t;

    // 8 phases x 4 lines, phase 0 in the low nibble
    localparam logic [31:0] XV_HEAD_PATTERN = {4'b0011, 4'b0110, 4'b1100, 4'b1001,
                                               4'b0011, 4'b0110, 4'b1100, 4'b1001};
    localparam logic [31:0] XV_TAIL_PATTERN = {4'b1001, 4'b1100, 4'b0110, 4'b0011,
                                               4'b1001, 4'b1100, 4'b0110, 4'b0011};

    localparam logic [7:0] MIN_STATE_WIDTH = 8'd4;

    function automatic logic [7:0] eff_width(input logic [7:0] w);
        return (w < MIN_STATE_WIDTH) ? MIN_STATE_WIDTH : w;
    endfunction

endpackage

// File: rtl/vblank_phase_timer.sv
// Phase counter / phase index for one blanking unit; updates on the clock after run/clear are sampled.
// No backpressure: run advances, clear zeroes, idle either clears or holds depending on RESUME_MODE.
module vblank_phase_timer #(
    parameter int NUM_PHASES  = 8,
    parameter int RESUME_MODE = 0,
    parameter int IDX_WD      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              run,
    input  logic [7:0]        width,
    output logic [7:0]        phase_cnt,
    output logic [IDX_WD-1:0] phase_idx,
    output logic              unit_end
);

    logic last_cnt;
    logic last_idx;

    assign last_cnt = (phase_cnt == (width - 8'd1));
    assign last_idx = (phase_idx == IDX_WD'(NUM_PHASES - 1));
    assign unit_end = run && last_cnt && last_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            phase_idx <= '0;
        end else if (clear) begin
            phase_cnt <= '0;
            phase_idx <= '0;
        end else if (run) begin
            if (last_cnt) begin
                phase_cnt <= '0;
                phase_idx <= last_idx ? '0 : phase_idx + IDX_WD'(1);
            end else begin
                phase_cnt <= phase_cnt + 8'd1;
            end
        end else if (RESUME_MODE == 0) begin
            // a unit cut by the window end starts over at the next window
            phase_cnt <= '0;
            phase_idx <= '0;
        end
    end

endmodule

// File: rtl/vblank_seq.sv
// Vertical-blanking sequencer: runs N-phase XV units inside an hcount window while blanking is requested.
// ov_xv is registered, 1 clock after the window; no backpressure, flag low aborts at any time.
module vblank_seq
    import vblank_seq_pkg::*;
#(
    parameter int                            V_WIDTH     = 4,
    parameter int                            NUM_PHASES  = 8,
    parameter logic [NUM_PHASES*V_WIDTH-1:0] XV_PATTERNS = XV_HEAD_PATTERN,
    parameter logic [V_WIDTH-1:0]            XV_DEFAULT  = 4'b0000,
    parameter int                            COMP_EVEN   = 2,
    parameter int                            COMP_ODD    = 1,
    parameter int                            RESUME_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_WD-1:0] iv_hcount,
    input  logic              i_blank_flag,
    input  logic [REG_WD-1:0] iv_blank_number,
    input  logic [REG_WD-1:0] iv_win_start,
    input  logic [REG_WD-1:0] iv_win_end,
    input  logic [7:0]        iv_state_width,
    output logic [V_WIDTH-1:0] ov_xv,
    output logic              o_busy,
    output logic              o_done,
    output logic [REG_WD-1:0] ov_unit_count
);

    localparam int IDX_WD = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    vb_state_t         state;
    logic [REG_WD-1:0] sh_number;
    logic [REG_WD-1:0] sh_win_start;
    logic [REG_WD-1:0] sh_win_end;
    logic [7:0]        sh_width;
    logic [7:0]        eff_w;
    logic              run;
    logic              timer_clear;
    logic [7:0]        phase_cnt;
    logic [IDX_WD-1:0] phase_idx;
    logic              unit_end;
    logic [7:0]        comp;
    logic [7:0]        thresh;
    logic [V_WIDTH-1:0] pat_cur;
    logic [V_WIDTH-1:0] pat_nxt;
    logic [V_WIDTH-1:0] xv_dec;

    assign eff_w       = eff_width(sh_width);
    assign run         = (state == ACTIVE) && (iv_hcount >= sh_win_start) && (iv_hcount <= sh_win_end);
    assign timer_clear = !i_blank_flag || (state != ACTIVE);

    vblank_phase_timer #(
        .NUM_PHASES  (NUM_PHASES),
        .RESUME_MODE (RESUME_MODE),
        .IDX_WD      (IDX_WD)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (timer_clear),
        .run       (run),
        .width     (eff_w),
        .phase_cnt (phase_cnt),
        .phase_idx (phase_idx),
        .unit_end  (unit_end)
    );

    // Edge compensation: leave each phase early by a parity-dependent number of clocks
    assign comp    = phase_idx[0] ? 8'(COMP_ODD) : 8'(COMP_EVEN);
    assign thresh  = (comp >= (eff_w - 8'd1)) ? 8'd0 : (eff_w - 8'd1 - comp);
    assign pat_cur = XV_PATTERNS[int'(phase_idx)*V_WIDTH +: V_WIDTH];
    assign pat_nxt = (phase_idx == IDX_WD'(NUM_PHASES - 1)) ? XV_DEFAULT
                   : XV_PATTERNS[(int'(phase_idx) + 1)*V_WIDTH +: V_WIDTH];
    assign xv_dec  = (phase_cnt <= thresh) ? pat_cur : pat_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sh_number     <= '0;
            sh_win_start  <= '0;
            sh_win_end    <= '0;
            sh_width      <= '0;
            ov_unit_count <= '0;
            ov_xv         <= XV_DEFAULT;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            ov_xv  <= (run && i_blank_flag) ? xv_dec : XV_DEFAULT;
            if (!i_blank_flag) begin
                state         <= IDLE;
                ov_unit_count <= '0;
                o_busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sh_number    <= iv_blank_number;
                        sh_win_start <= iv_win_start;
                        sh_win_end   <= iv_win_end;
                        sh_width     <= iv_state_width;
                        if (iv_blank_number != '0) begin
                            state  <= ACTIVE;
                            o_busy <= 1'b1;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (unit_end && (ov_unit_count != sh_number)) begin
                            ov_unit_count <= ov_unit_count + REG_WD'(1);
                            if ((ov_unit_count + REG_WD'(1)) == sh_number) begin
                                state  <= DONE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vblank_seq.sv
// Bench for vblank_seq: two instances (hold/restart resume modes) share stimulus; a queue-based scoreboard
// holds per-clock expectations from a unit-position model, plus directed end-of-scenario checks.
module tb_vblank_seq;
    import vblank_seq_pkg::*;

    localparam int          NP   = 8;
    localparam int          CE   = 2;
    localparam int          CO   = 1;
    localparam logic [31:0] PATS = 32'h8765_4321;
    localparam logic [3:0]  XDEF = 4'hF;

    typedef struct packed {
        logic [3:0]        xv;
        logic              busy;
        logic              done;
        logic [REG_WD-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [REG_WD-1:0] hcount = '0;
    logic              flag = 1'b0;
    logic [REG_WD-1:0] number = '0;
    logic [REG_WD-1:0] ws = '0;
    logic [REG_WD-1:0] we = '0;
    logic [7:0]        width = '0;

    logic [3:0]        xv0, xv1;
    logic              busy0, busy1, done0, busy_dummy;
    logic              done1;
    logic [REG_WD-1:0] cnt0, cnt1;

    logic [REG_WD-1:0] s_number = '0;
    logic [REG_WD-1:0] s_ws = '0;
    logic [REG_WD-1:0] s_we = '0;
    logic [7:0]        s_width = '0;

    exp_t sb0[$];
    exp_t sb1[$];
    int   m_st[2], m_pos[2], m_cnt[2], m_num[2], m_ws[2], m_we[2], m_w[2];

    int n_checks = 0;
    int n_fail   = 0;
    int line_no  = 0;
    int n_done0, n_done1, done_line0, done_line1, done_h0, done_h1, busy_seen;

    assign busy_dummy = 1'b0;

    always #5 clk = ~clk;

    vblank_seq #(.V_WIDTH(4), .NUM_PHASES(NP), .XV_PATTERNS(PATS), .XV_DEFAULT(XDEF),
                 .COMP_EVEN(CE), .COMP_ODD(CO), .RESUME_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .iv_hcount(hcount), .i_blank_flag(flag),
        .iv_blank_number(number), .iv_win_start(ws), .iv_win_end(we), .iv_state_width(width),
        .ov_xv(xv0), .o_busy(busy0), .o_done(done0), .ov_unit_count(cnt0));

    vblank_seq #(.V_WIDTH(4), .NUM_PHASES(NP), .XV_PATTERNS(PATS), .XV_DEFAULT(XDEF),
                 .COMP_EVEN(CE), .COMP_ODD(CO), .RESUME_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .iv_hcount(hcount), .i_blank_flag(flag),
        .iv_blank_number(number), .iv_win_start(ws), .iv_win_end(we), .iv_state_width(width),
        .ov_xv(xv1), .o_busy(busy1), .o_done(done1), .ov_unit_count(cnt1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // XV expected at run position pos (clocks since unit start) for phase width w
    function automatic logic [3:0] model_xv(input int pos, input int w);
        logic [31:0] p;
        int k, c, t;
        p = PATS;
        k = pos / w;
        c = pos % w;
        t = w - 1 - (((k % 2) == 1) ? CO : CE);
        if (t < 0) t = 0;
        if (c <= t) return p[k*4 +: 4];
        if (k == NP - 1) return XDEF;
        return p[(k+1)*4 +: 4];
    endfunction

    task automatic model(input int m, input logic f, input int h, output exp_t e);
        e.xv   = XDEF;
        e.done = 1'b0;
        if (!f) begin
            m_st[m] = 0; m_pos[m] = 0; m_cnt[m] = 0;
        end else begin
            case (m_st[m])
                0: begin
                    m_num[m] = int'(s_number);
                    m_ws[m]  = int'(s_ws);
                    m_we[m]  = int'(s_we);
                    m_w[m]   = (s_width < 8'd4) ? 4 : int'(s_width);
                    if (m_num[m] != 0) m_st[m] = 1;
                    else begin m_st[m] = 2; e.done = 1'b1; end
                end
                1: begin
                    if (h >= m_ws[m] && h <= m_we[m]) begin
                        e.xv = model_xv(m_pos[m], m_w[m]);
                        if (m_pos[m] == NP*m_w[m] - 1) begin
                            m_pos[m] = 0;
                            m_cnt[m]++;
                            if (m_cnt[m] == m_num[m]) begin m_st[m] = 2; e.done = 1'b1; end
                        end else begin
                            m_pos[m]++;
                        end
                    end else if (m == 0) begin
                        m_pos[m] = 0;
                    end
                end
                default: ;
            endcase
        end
        e.busy = (m_st[m] == 1);
        e.cnt  = REG_WD'(m_cnt[m]);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_pos[m] = 0; m_cnt[m] = 0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    // Compare the edge just past, then drive the next clock's inputs and queue its expectation
    task automatic cyc(input logic f, input int h);
        exp_t e;
        @(negedge clk);
        if (sb0.size() != 0) begin
            e = sb0.pop_front();
            check("xv_m0", 32'(xv0), 32'(e.xv));
            check("busy_m0", 32'(busy0), 32'(e.busy));
            check("done_m0", 32'(done0), 32'(e.done));
            check("cnt_m0", 32'(cnt0), 32'(e.cnt));
        end
        if (sb1.size() != 0) begin
            e = sb1.pop_front();
            check("xv_m1", 32'(xv1), 32'(e.xv));
            check("busy_m1", 32'(busy1), 32'(e.busy));
            check("done_m1", 32'(done1), 32'(e.done));
            check("cnt_m1", 32'(cnt1), 32'(e.cnt));
        end
        if (done0) begin n_done0++; done_line0 = line_no; done_h0 = int'(hcount); end
        if (done1) begin n_done1++; done_line1 = line_no; done_h1 = int'(hcount); end
        if (busy0 || busy1 || busy_dummy) busy_seen++;
        flag   = f;
        hcount = REG_WD'(h);
        number = s_number;
        ws     = s_ws;
        we     = s_we;
        width  = s_width;
        model(0, f, h, e); sb0.push_back(e);
        model(1, f, h, e); sb1.push_back(e);
    endtask

    task automatic clr_mon();
        n_done0 = 0; n_done1 = 0; done_line0 = -1; done_line1 = -1;
        done_h0 = -1; done_h1 = -1; busy_seen = 0; line_no = 0;
    endtask

    task automatic run_lines(input int n);
        for (int l = 0; l < n; l++) begin
            for (int h = 0; h < 300; h++) cyc(1'b1, h);
            line_no++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0);
    endtask

    task automatic setup(input int num, input int w_s, input int w_e, input int w);
        s_number = REG_WD'(num);
        s_ws     = REG_WD'(w_s);
        s_we     = REG_WD'(w_e);
        s_width  = 8'(w);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_xv0"}, 32'(xv0), 32'(XDEF));
        check({tag, "_xv1"}, 32'(xv1), 32'(XDEF));
        check({tag, "_busy"}, 32'({busy0, busy1}), 32'd0);
        check({tag, "_done"}, 32'({done0, done1}), 32'd0);
        check({tag, "_cnt0"}, 32'(cnt0), 32'd0);
        check({tag, "_cnt1"}, 32'(cnt1), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clr_mon();
        #1 reset_n = 1'b0;
        #1 check_reset_vals("reset");
        idle(3);
        reset_n = 1'b1;
        idle(3);

        // Two full units, one per line
        setup(2, 100, 227, 16);
        clr_mon();
        run_lines(2);
        check("two_cnt0", 32'(cnt0), 32'd2);
        check("two_cnt1", 32'(cnt1), 32'd2);
        run_lines(1);
        check("two_ndone", 32'(n_done0 + n_done1), 32'd2);
        check("two_done_line", 32'(done_line0), 32'd1);
        check("two_done_h", 32'(done_h0), 32'd227);
        idle(3);

        // Zero units: immediate done, never busy
        setup(0, 100, 227, 16);
        clr_mon();
        for (int i = 0; i < 8; i++) cyc(1'b1, 120 + i);
        idle(1);
        check("zero_busy_seen", 32'(busy_seen), 32'd0);
        check("zero_ndone0", 32'(n_done0), 32'd1);
        check("zero_ndone1", 32'(n_done1), 32'd1);
        idle(2);

        // Unit spanning two 64-clock windows
        setup(1, 100, 163, 16);
        clr_mon();
        run_lines(3);
        check("res_ndone1", 32'(n_done1), 32'd1);
        check("res_done_line1", 32'(done_line1), 32'd1);
        check("res_done_h1", 32'(done_h1), 32'd163);
        check("res_ndone0", 32'(n_done0), 32'd0);
        idle(3);

        // Abort inside phase 3, then restart mid-window
        setup(2, 100, 227, 16);
        clr_mon();
        for (int h = 0; h < 153; h++) cyc(1'b1, h);
        for (int h = 153; h < 156; h++) cyc(1'b0, h);
        check("abort_xv0", 32'(xv0), 32'(XDEF));
        check("abort_cnt0", 32'(cnt0), 32'd0);
        check("abort_ndone", 32'(n_done0 + n_done1), 32'd0);
        for (int h = 156; h < 300; h++) cyc(1'b1, h);
        line_no++;
        run_lines(2);
        idle(3);

        // Shadowed width ignored mid-request; next request clamps width 2 to 4
        setup(1, 100, 227, 16);
        clr_mon();
        for (int h = 0; h < 300; h++) begin
            if (h == 120) s_width = 8'd2;
            cyc(1'b1, h);
        end
        check("shadow_done_h", 32'(done_h0), 32'd227);
        idle(2);
        s_number = REG_WD'(3);
        clr_mon();
        run_lines(1);
        check("clamp_done_h0", 32'(done_h0), 32'd195);
        check("clamp_done_h1", 32'(done_h1), 32'd195);
        idle(2);

        // Inverted window never runs, stays busy
        setup(1, 200, 100, 16);
        clr_mon();
        run_lines(1);
        check("inv_busy", 32'({busy0, busy1}), 32'b11);
        check("inv_ndone", 32'(n_done0 + n_done1), 32'd0);
        idle(2);

        // Asynchronous reset in the middle of the second unit
        setup(2, 100, 227, 16);
        clr_mon();
        run_lines(1);
        for (int h = 0; h < 171; h++) cyc(1'b1, h);
        check("pre_rst_busy", 32'({busy0, busy1}), 32'b11);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_rst");
        model_reset();
        idle(3);
        reset_n = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vblank_seq.md
# vblank_seq

Parametrised vertical-blanking (fast-dump) sequencer for the CCD timing path. While a frame-level blanking request is active, it drives the XV vertical clocks through a programmable N-phase pattern inside a per-line hcount window. It repeats the pattern for a programmed number of units and signals completion. It replaces the fixed 8-phase head/tail blank generators and adds:
- runtime window and phase width,
- per-phase-parity edge compensation,
- optional hold/resume of a unit that spans lines,
- status outputs.

## Interface
- `V_WIDTH`, 4, number of XV lines.
- `NUM_PHASES`, 8, phases per unit (2..16).
- `XV_PATTERNS`, NUM_PHASES*V_WIDTH-bit vector. Phase k pattern is bits [k*V_WIDTH +: V_WIDTH].
- `XV_DEFAULT`, 4'b0000, XV value outside blanking.
- `COMP_EVEN`, 2, clocks early the transition out of an even phase occurs.
- `COMP_ODD`, 1, clocks early the transition out of an odd phase occurs.
- `RESUME_MODE`, 0. 0: a unit cut by the window end restarts at the next window. 1: it holds and resumes.
- `clk`  input  1  timing clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `iv_hcount`  input  REG_WD  line pixel counter.
- `i_blank_flag`  input  1  frame-level blanking request. Low aborts.
- `iv_blank_number`  input  REG_WD  units to run. 0 means none.
- `iv_win_start`, `iv_win_end`  input  REG_WD  inclusive hcount window.
- `iv_state_width`  input  8  clocks per phase.
- `ov_xv`  output  V_WIDTH  vertical clock levels, registered.
- `o_busy`  output  1  high in ACTIVE.
- `o_done`  output  1  one-clock pulse when the last unit completes.
- `ov_unit_count`  output  REG_WD  units completed this request.

## Operation
- States: IDLE, ACTIVE, DONE.
- Shadow capture:
  - On the IDLE→(ACTIVE|DONE) transition, `iv_blank_number`, `iv_win_start`, `iv_win_end` and `iv_state_width` are captured into shadows.
  - Input changes after capture are ignored until the next IDLE.
  - Effective width W = max(shadow width, 4).
- Transitions out of IDLE (when `i_blank_flag`=1):
  - shadow number ≠ 0 → ACTIVE.
  - shadow number = 0 → DONE with `o_done` pulse.
- `i_blank_flag`=0 in any state → IDLE next clock. `phase_cnt`, `phase_idx` and `ov_unit_count` clear.
- `run` = ACTIVE and win_start ≤ hcount ≤ win_end.
- Counters while `run`:
  - `phase_cnt` counts 0..W-1 and wraps.
  - At W-1, `phase_idx` increments, wrapping from NUM_PHASES-1 to 0.
- Unit end is `run` with `phase_idx`=NUM_PHASES-1 and `phase_cnt`=W-1. At unit end:
  - `ov_unit_count` increments.
  - If the new count equals the shadow number: → DONE, `o_done`=1 for that clock.
- Out of window in ACTIVE:
  - RESUME_MODE 0: `phase_cnt` and `phase_idx` clear.
  - RESUME_MODE 1: both hold.
- XV value for phase k:
  - Threshold T(k) = W-1-comp(k), saturating at 0. comp(k) = COMP_EVEN for even k, COMP_ODD for odd k.
  - `phase_cnt` ≤ T(k) → pattern[k]. Otherwise → pattern[k+1], or XV_DEFAULT when k = NUM_PHASES-1.
- Whenever not `run`, XV is XV_DEFAULT.
- DONE holds XV_DEFAULT and `ov_unit_count` until `i_blank_flag` falls.

## Timing
- Reset values: `ov_xv`=XV_DEFAULT, `o_busy`=0, `o_done`=0, `ov_unit_count`=0, state IDLE, all counters 0.
- `ov_xv` is registered. It reflects the `run`, `phase_idx` and `phase_cnt` of the previous clock, so latency is 1 clock from hcount entering the window.
- `o_busy` rises 1 clock after the flag is sampled high and falls the clock the DONE transition registers.
- `o_done` and the final `ov_unit_count` increment land on the same clock.
- Simultaneous events:
  - Unit end on the last in-window clock: the unit counts as complete and the counters wrap to 0 regardless of RESUME_MODE.
  - Flag falling and unit end on the same clock: the abort wins. No `o_done`, counters clear.
- Window with win_start > win_end: `run` is never true and the block stays in ACTIVE.
- `ov_unit_count` saturates at the shadow number and never wraps.

## Structure
- The shared timing define header holds REG_WD, the state encodings (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2) and the default XV pattern vectors for head and tail blank.
- Sub-module `vblank_phase_timer` holds `phase_cnt`/`phase_idx` with the clear/hold/advance controls and the unit-end flag. The top holds the FSM, shadows, unit counter and XV decode.

## Test plan
Common settings: V_WIDTH=4, NUM_PHASES=8, W=16, COMP_EVEN=2, COMP_ODD=1, window 100..227, hcount 0..299 per line.

- **Two units, RESUME_MODE=0.** number=2.
  - Line 1: `ov_xv` = pattern[0] for 14 clocks starting at hcount 101, then pattern[1] for 2 clocks.
  - Unit 1 ends at hcount 227 of line 1; unit 2 ends at hcount 227 of line 2.
  - `o_done` pulses there, `ov_unit_count`=2, and XV is default afterwards.
- **Zero units.** number=0, flag high → `o_done` pulses 1 clock after flag high, `o_busy` never asserts, XV stays default.
- **Resume across lines.** Window 100..163 (64 clocks), RESUME_MODE=1, number=1.
  - Line 2 continues at phase_idx 4.
  - `o_done` pulses at hcount 163 of line 2.
  - Same stimulus with RESUME_MODE=0: `o_done` never pulses.
- **Abort.** Flag drops at phase 3 → XV default the next clock, count 0, no `o_done`. Reassert → restarts at phase 0.
- **Shadow and clamp.** Change `iv_state_width` from 16 to 2 mid-ACTIVE → no effect. Next request uses W=4 (clamped), with the phase 0 transition at `phase_cnt` 2.
- **Reset.** Assert `reset_n` mid-unit → outputs go to reset values immediately without a clock edge.
